// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU control FSM with retirement counter
// and sticky illegal-opcode flag; all controls are decoded combinationally from state.
module multicycle_control #(
  parameter logic [6:0] ALU_R     = 7'b0110011,
  parameter logic [6:0] ALU_I     = 7'b0010011,
  parameter logic [6:0] BRANCH_EQ = 7'b1100011,
  parameter logic [6:0] JUMP      = 7'b1101111,
  parameter logic [6:0] LOAD      = 7'b0000011,
  parameter logic [6:0] STORE     = 7'b0100011
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        enable,
  input  logic [6:0]  opcode,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_2_reg,
  output logic        alu_src,
  output logic        reg_write,
  output logic        branch,
  output logic        jump,
  output logic [1:0]  alu_op,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [31:0] retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [6:0]  op_q;
  logic        illegal_q;
  logic [31:0] retired_q;
  logic        retire;
  logic        opcode_ok;

  always_comb begin
    opcode_ok = (opcode == ALU_R) || (opcode == ALU_I) || (opcode == BRANCH_EQ) ||
                (opcode == JUMP)  || (opcode == LOAD)  || (opcode == STORE);
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE:   if (enable) state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = opcode_ok ? S_EXEC : S_ERROR;
      S_EXEC: begin
        if (op_q == ALU_R || op_q == ALU_I) state_d = S_WB;
        else if (op_q == LOAD || op_q == STORE) state_d = S_MEM;
        else if (op_q == BRANCH_EQ || op_q == JUMP) retire = 1'b1;
        else state_d = S_ERROR;
      end
      S_MEM: begin
        if (mem_ready) begin
          if (op_q == LOAD) state_d = S_WB;
          else retire = 1'b1;
        end
      end
      S_WB:    retire = 1'b1;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
    // Enable only matters at retirement, so a mid-instruction drop lets it finish.
    if (retire) state_d = enable ? S_FETCH : S_IDLE;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= S_IDLE;
      op_q      <= 7'd0;
      illegal_q <= 1'b0;
      retired_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
        if (!opcode_ok) illegal_q <= 1'b1;
      end
      if (retire) retired_q <= retired_q + 32'd1;
    end
  end

  always_comb begin
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_2_reg = 1'b0;
    alu_src   = 1'b0;
    reg_write = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    alu_op    = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_EXEC: begin
        if (op_q == ALU_R) begin
          alu_op = 2'b10;
        end else if (op_q == ALU_I || op_q == LOAD || op_q == STORE) begin
          alu_src = 1'b1;
        end else if (op_q == BRANCH_EQ) begin
          alu_op = 2'b01;
          branch = 1'b1;
        end else if (op_q == JUMP) begin
          jump     = 1'b1;
          pc_write = 1'b1;
        end
      end
      S_MEM: begin
        mem_read  = (op_q == LOAD);
        mem_write = (op_q == STORE);
      end
      S_WB: begin
        reg_write = 1'b1;
        mem_2_reg = (op_q == LOAD);
      end
      default: ;
    endcase
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed bench; expected per-cycle trace is built
// from instruction schedules (opcode, wait counts, enable plan) and compared each cycle.
module tb_multicycle_control;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_BE = 7'b1100011;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;

  // Control vector order: pc_write ir_write mem_read mem_write mem_2_reg alu_src reg_write branch jump
  localparam logic [8:0] C_PC  = 9'b100000000;
  localparam logic [8:0] C_IR  = 9'b010000000;
  localparam logic [8:0] C_MR  = 9'b001000000;
  localparam logic [8:0] C_MW  = 9'b000100000;
  localparam logic [8:0] C_M2R = 9'b000010000;
  localparam logic [8:0] C_AS  = 9'b000001000;
  localparam logic [8:0] C_RW  = 9'b000000100;
  localparam logic [8:0] C_BR  = 9'b000000010;
  localparam logic [8:0] C_JP  = 9'b000000001;

  logic clk = 1'b0;
  logic arst_n, enable, mem_ready;
  logic [6:0] opcode;
  logic pc_write, ir_write, mem_read, mem_write, mem_2_reg, alu_src, reg_write, branch, jump;
  logic [1:0] alu_op;
  logic illegal;
  logic [2:0] state;
  logic [31:0] retired;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct packed {
    logic        en;
    logic        mr;
    logic [6:0]  opc;
    logic [2:0]  st;
    logic [8:0]  ctl;
    logic [1:0]  aop;
    logic        ill;
    logic [31:0] ret;
  } ent_t;

  ent_t q[$];
  logic [31:0] m_retired;

  multicycle_control dut (
    .clk(clk), .arst_n(arst_n), .enable(enable), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .mem_2_reg(mem_2_reg), .alu_src(alu_src), .reg_write(reg_write), .branch(branch),
    .jump(jump), .alu_op(alu_op), .illegal(illegal), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [8:0] ctl_now();
    return {pc_write, ir_write, mem_read, mem_write, mem_2_reg, alu_src, reg_write, branch, jump};
  endfunction

  task automatic push(input logic en, input logic mr, input logic [6:0] opc,
                      input logic [2:0] st, input logic [8:0] ctl, input logic [1:0] aop,
                      input logic ill);
    ent_t e;
    e.en = en; e.mr = mr; e.opc = opc; e.st = st; e.ctl = ctl; e.aop = aop;
    e.ill = ill; e.ret = m_retired;
    q.push_back(e);
  endtask

  task automatic add_idle(input logic en, input int n);
    for (int i = 0; i < n; i++) push(en, 1'b1, 7'd0, 3'd0, 9'd0, 2'd0, 1'b0);
  endtask

  task automatic add_fetch(input int fw);
    for (int i = 0; i < fw; i++) push(1'b1, 1'b0, 7'd0, 3'd1, C_MR, 2'd0, 1'b0);
    push(1'b1, 1'b1, 7'd0, 3'd1, C_MR | C_IR | C_PC, 2'd0, 1'b0);
  endtask

  // One supported instruction from FETCH to retirement. The opcode input is
  // scrambled after DECODE so later states must rely on the latched copy.
  task automatic add_instr(input logic [6:0] opc, input int fw, input int mw,
                           input logic en_mid, input logic next_en);
    logic [6:0] junk;
    junk = ~opc;
    add_fetch(fw);
    push(1'b1, 1'b1, opc, 3'd2, 9'd0, 2'd0, 1'b0);
    if (opc == OP_R) begin
      push(en_mid, 1'b1, junk, 3'd3, 9'd0, 2'b10, 1'b0);
      push(next_en, 1'b1, junk, 3'd5, C_RW, 2'd0, 1'b0);
      m_retired++;
    end else if (opc == OP_I) begin
      push(en_mid, 1'b1, junk, 3'd3, C_AS, 2'b00, 1'b0);
      push(next_en, 1'b1, junk, 3'd5, C_RW, 2'd0, 1'b0);
      m_retired++;
    end else if (opc == OP_BE) begin
      push(next_en, 1'b1, junk, 3'd3, C_BR, 2'b01, 1'b0);
      m_retired++;
    end else if (opc == OP_J) begin
      push(next_en, 1'b1, junk, 3'd3, C_JP | C_PC, 2'b00, 1'b0);
      m_retired++;
    end else begin
      push(en_mid, 1'b1, junk, 3'd3, C_AS, 2'b00, 1'b0);
      for (int i = 0; i < mw; i++)
        push(en_mid, 1'b0, junk, 3'd4, (opc == OP_LD) ? C_MR : C_MW, 2'd0, 1'b0);
      if (opc == OP_LD) begin
        push(en_mid, 1'b1, junk, 3'd4, C_MR, 2'd0, 1'b0);
        push(next_en, 1'b1, junk, 3'd5, C_RW | C_M2R, 2'd0, 1'b0);
      end else begin
        push(next_en, 1'b1, junk, 3'd4, C_MW, 2'd0, 1'b0);
      end
      m_retired++;
    end
  endtask

  task automatic run_queue();
    ent_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(negedge clk);
      enable = e.en; mem_ready = e.mr; opcode = e.opc;
      #1;
      check("state", {29'd0, state}, {29'd0, e.st});
      check("controls", {23'd0, ctl_now()}, {23'd0, e.ctl});
      check("alu_op", {30'd0, alu_op}, {30'd0, e.aop});
      check("illegal", {31'd0, illegal}, {31'd0, e.ill});
      check("retired", retired, e.ret);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_state"}, {29'd0, state}, 32'd0);
    check({name, "_controls"}, {23'd0, ctl_now()}, 32'd0);
    check({name, "_alu_op"}, {30'd0, alu_op}, 32'd0);
    check({name, "_illegal"}, {31'd0, illegal}, 32'd0);
    check({name, "_retired"}, retired, 32'd0);
  endtask

  initial begin
    int sz;
    arst_n = 1'b0; enable = 1'b0; mem_ready = 1'b0; opcode = 7'd0;
    m_retired = 32'd0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    arst_n = 1'b1;

    // ALU_R with mem_ready high: 1,2,3,5 then straight back to FETCH.
    add_idle(1'b1, 1);
    add_instr(OP_R, 0, 0, 1'b1, 1'b1);
    add_instr(OP_I, 0, 0, 1'b1, 1'b1);
    add_instr(OP_BE, 0, 0, 1'b1, 1'b1);
    sz = q.size();
    add_instr(OP_LD, 0, 3, 1'b1, 1'b1);
    check("load_len", q.size() - sz, 32'd8);
    add_instr(OP_ST, 1, 2, 1'b0, 1'b0);
    add_idle(1'b0, 2);
    run_queue();
    check("retired_after_5", retired, 32'd5);

    // Preload the counter, then a JUMP must wrap it to zero.
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    m_retired = 32'hFFFF_FFFF;
    check("preload", retired, 32'hFFFF_FFFF);
    add_idle(1'b1, 1);
    add_instr(OP_J, 0, 0, 1'b1, 1'b0);
    add_idle(1'b0, 1);
    run_queue();
    check("retired_wrap", retired, 32'd0);

    // Unsupported opcode: ERROR is sticky regardless of enable and mem_ready.
    add_idle(1'b1, 1);
    add_fetch(2);
    push(1'b1, 1'b1, 7'b1111111, 3'd2, 9'd0, 2'd0, 1'b0);
    for (int i = 0; i < 100; i++) push(i[0], 1'b1, 7'd0, 3'd6, 9'd0, 2'd0, 1'b1);
    run_queue();
    check("illegal_sticky", {31'd0, illegal}, 32'd1);
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    check_all_zero("error_reset");
    @(negedge clk);
    arst_n = 1'b1; enable = 1'b0;
    m_retired = 32'd0;

    // Reset while FETCH waits on memory: mem_read must drop immediately.
    add_idle(1'b1, 1);
    for (int i = 0; i < 3; i++) push(1'b1, 1'b0, 7'd0, 3'd1, C_MR, 2'd0, 1'b0);
    run_queue();
    #2;
    arst_n = 1'b0;
    #1;
    check("fetch_reset_mem_read", {31'd0, mem_read}, 32'd0);
    check_all_zero("fetch_reset");
    @(negedge clk);
    arst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have port `clk`: input, 1 bit, single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port `arst_n`: input, 1 bit, asynchronous active-low reset.
REQ-003 The block SHALL have port `enable`: input, 1 bit, run request, sampled in IDLE and at each instruction retirement.
REQ-004 The block SHALL have port `opcode`: input, 7 bits, instruction opcode from the instruction register, valid from DECODE onward.
REQ-005 The block SHALL have port `mem_ready`: input, 1 bit, memory completion strobe for the current read or write.
REQ-006 The block SHALL have outputs `pc_write`, `ir_write`, `mem_read`, `mem_write`, `mem_2_reg`, `alu_src`, `reg_write`, `branch` and `jump`: 1 bit each, datapath controls.
REQ-007 The block SHALL have output `alu_op`: 2 bits; 00 = add, 01 = sub, 10 = R-type decode.
REQ-008 The block SHALL have output `illegal`: 1 bit, sticky, asserted when an unsupported opcode is decoded.
REQ-009 The block SHALL have output `state`: 3 bits, current FSM state encoding.
REQ-010 The block SHALL have output `retired`: 32 bits, count of retired instructions.
REQ-011 The block SHALL have opcode parameters: ALU_R = 0110011, ALU_I = 0010011, BRANCH_EQ = 1100011, JUMP = 1101111, LOAD = 0000011, STORE = 0100011.

Function
REQ-012 The FSM SHALL have states IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, ERROR = 6.
REQ-013 IDLE SHALL go to FETCH when `enable` = 1 and stay in IDLE otherwise; all controls are 0 in IDLE.
REQ-014 FETCH SHALL hold `mem_read` = 1 every cycle until `mem_ready`; in the cycle `mem_ready` = 1 it pulses `ir_write` = 1 and `pc_write` = 1 (PC+4) and goes to DECODE.
REQ-015 DECODE SHALL latch `opcode` into an internal op register used by all later states; a supported opcode goes to EXEC, any other opcode goes to ERROR.
REQ-016 EXEC for ALU_R SHALL drive `alu_src` = 0 and `alu_op` = 10, then go to WB.
REQ-017 EXEC for ALU_I, LOAD and STORE SHALL drive `alu_src` = 1 and `alu_op` = 00; ALU_I goes to WB, LOAD and STORE go to MEM.
REQ-018 EXEC for BRANCH_EQ SHALL drive `alu_src` = 0, `alu_op` = 01 and `branch` = 1; the datapath gates the PC update with the zero flag; the instruction retires.
REQ-019 EXEC for JUMP SHALL drive `jump` = 1 and `pc_write` = 1 for one cycle; the instruction retires.
REQ-020 MEM SHALL hold `mem_read` = 1 (LOAD) or `mem_write` = 1 (STORE) until `mem_ready` = 1; LOAD then goes to WB and STORE retires.
REQ-021 WB SHALL assert `reg_write` = 1 for exactly one cycle, with `mem_2_reg` = 1 for LOAD and 0 otherwise; the instruction retires.
REQ-022 Retirement SHALL increment `retired` by 1, wrapping from FFFFFFFF to 0, and go to FETCH if `enable` = 1, else to IDLE.
REQ-023 Deasserting `enable` mid-instruction SHALL NOT abort the instruction; it takes effect only at retirement.
REQ-024 `mem_ready` outside FETCH/MEM SHALL be ignored; `mem_ready` held high SHALL give a minimum latency of 4 cycles for ALU_R/ALU_I, 5 for LOAD, 4 for STORE, and 3 for BRANCH_EQ/JUMP.
REQ-025 ERROR SHALL set `illegal` = 1, hold all other controls at 0, and be left only by reset; `retired` does not increment.
REQ-026 Controls not listed for a state SHALL be 0; outputs are combinational from state, the op register and `mem_ready`.

Reset
REQ-027 `arst_n` = 0 SHALL immediately force state IDLE, `retired` = 0, `illegal` = 0, op register = 0 and all controls to 0, including mid-memory-access.
REQ-028 Release of reset SHALL be synchronous to `clk`; the first transition occurs at the first rising edge with `arst_n` = 1.

Verification
REQ-029 The bench SHALL cover: `enable` = 1, `mem_ready` = 1, opcode 0110011 -> states 1, 2, 3, 5, 1; one `reg_write` pulse; `retired` = 1 after 4 cycles.
REQ-030 The bench SHALL cover: LOAD with `mem_ready` low for 3 cycles in MEM -> `mem_read` held 3+1 cycles, then WB with `mem_2_reg` = 1; total 8 cycles.
REQ-031 The bench SHALL cover: opcode 1111111 -> ERROR, `illegal` = 1 persists for 100 cycles; `arst_n` pulse -> IDLE, `illegal` = 0.
REQ-032 The bench SHALL cover: `enable` dropped during EXEC of STORE -> STORE completes with `mem_write` pulse, `retired` += 1, state IDLE.
REQ-033 The bench SHALL cover: `retired` preloaded to FFFFFFFF by forcing, then a JUMP retires -> `retired` = 0 and one `jump` + `pc_write` pulse in EXEC.
REQ-034 The bench SHALL cover: `arst_n` asserted during FETCH wait -> all outputs 0 in the same cycle, `mem_read` drops immediately.
